// File: rtl/mux2_arb.sv
// Two-requester valid/ready arbiter sharing one consumer through a 2:1 data mux.
// Define MUX2_ARB_ROUND_ROBIN_EN for last-winner tie breaking; otherwise A wins every tie.

module mux2 #(
    parameter int BITS = 1
) (
    input  logic            sel,
    input  logic [BITS-1:0] in0,
    input  logic [BITS-1:0] in1,
    output logic [BITS-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module mux2_arb #(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    input  logic [BITS-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [BITS-1:0] b_data,
    output logic            b_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    input  logic            out_ready,
    output logic            select
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    state_t tie_grant;
    logic   transfer_a;
    logic   transfer_b;

`ifdef MUX2_ARB_ROUND_ROBIN_EN
    logic last_b;
`endif

    function automatic state_t pick(input logic av, input logic bv, input state_t tie);
        if (av && bv)
            return tie;
        else if (av)
            return GRANT_A;
        else if (bv)
            return GRANT_B;
        else
            return IDLE;
    endfunction

    assign transfer_a = (state == GRANT_A) && a_valid && out_ready;
    assign transfer_b = (state == GRANT_B) && b_valid && out_ready;

    // On a transfer the current grantee is the newest winner, so a tie goes to the other side.
    always_comb begin
`ifdef MUX2_ARB_ROUND_ROBIN_EN
        case (state)
            GRANT_A: tie_grant = GRANT_B;
            GRANT_B: tie_grant = GRANT_A;
            default: tie_grant = last_b ? GRANT_A : GRANT_B;
        endcase
`else
        tie_grant = GRANT_A;
`endif
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = pick(a_valid, b_valid, tie_grant);
            GRANT_A: begin
                if (transfer_a)
                    next_state = pick(a_valid, b_valid, tie_grant);
                else if (!a_valid)
                    next_state = IDLE;
            end
            GRANT_B: begin
                if (transfer_b)
                    next_state = pick(a_valid, b_valid, tie_grant);
                else if (!b_valid)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            select <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == GRANT_A)
                select <= 1'b0;
            else if (next_state == GRANT_B)
                select <= 1'b1;
        end
    end

`ifdef MUX2_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_b <= 1'b1;
        else if (transfer_a)
            last_b <= 1'b0;
        else if (transfer_b)
            last_b <= 1'b1;
    end
`endif

    always_comb begin
        out_valid = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            GRANT_A: begin
                out_valid = a_valid;
                a_ready   = out_ready;
            end
            GRANT_B: begin
                out_valid = b_valid;
                b_ready   = out_ready;
            end
            default: ;
        endcase
    end

    mux2 #(.BITS(BITS)) u_mux (
        .sel (select),
        .in0 (a_data),
        .in1 (b_data),
        .out (out_data)
    );

`ifdef FORMAL
    always_comb begin
        assert (!(a_ready && b_ready));
        if (state == IDLE)
            assert (!out_valid);
        assert (out_data == (select ? b_data : a_data));
    end
`endif

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 SHALL have parameter BITS, default 1, meaning the payload width of each requester and of the output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports a_valid, input, 1; a_data, input, BITS; a_ready, output, 1: requester A handshake.
REQ-005 SHALL have ports b_valid, input, 1; b_data, input, BITS; b_ready, output, 1: requester B handshake.
REQ-006 SHALL have ports out_valid, output, 1; out_data, output, BITS; out_ready, input, 1: shared-consumer handshake.
REQ-007 SHALL have port select, output, 1: the registered shared-datapath select, 0 = A and 1 = B.

Function
REQ-008 SHALL implement the states IDLE, GRANT_A and GRANT_B, held in a registered state and updated only on the clk rising edge.
REQ-009 SHALL produce out_data = select ? b_data : a_data through a 2:1 mux instance, with no register on the data path.
REQ-010 SHALL drive the following per state: in IDLE, out_valid=0 and a_ready=b_ready=0; in GRANT_A, out_valid=a_valid, a_ready=out_ready and b_ready=0; in GRANT_B, the mirror of GRANT_A.
REQ-011 SHALL define a transfer as the granted requester's valid and out_ready both high in the same cycle.
REQ-012 SHALL transition from IDLE as follows: if only one requester is valid, grant it on the next edge; if both are valid, apply the tie rule (REQ-015); if neither is valid, stay in IDLE.
REQ-013 SHALL, in GRANT_x on a transfer, choose the next state from the valids sampled in that cycle using the same rules as IDLE, so back-to-back transfers have no bubble.
REQ-014 SHALL, in GRANT_x when x_valid drops without a transfer (a requester protocol violation), return to IDLE on the next edge; without a transfer the grant is otherwise held indefinitely.
REQ-015 SHALL resolve ties with a last-winner register updated on every transfer, so that on a tie the requester that did not win last is granted.
REQ-016 SHALL have select follow the state: 0 in GRANT_A, 1 in GRANT_B, and unchanged in IDLE.
REQ-017 SHALL have a latency of exactly one cycle from a valid rising in IDLE to out_valid.
REQ-018 SHALL let a requester with valid held high win within two transfers, i.e. there is no starvation.
REQ-019 SHALL, under FORMAL, assert that a_ready and b_ready are never both high, that out_valid is low in IDLE, and that out_data equals the selected input.

Reset
REQ-020 SHALL, while reset_n is low, immediately and asynchronously force state=IDLE, select=0 and last-winner=B, which makes A win the first tie.
REQ-021 SHALL make all outputs reset-derived: out_valid=0, a_ready=0 and b_ready=0 while in reset.
REQ-022 SHALL, on reset asserted mid-grant, drop the transfer in progress with no partial-state retention.
REQ-023 SHALL release reset synchronously to clk at the integration level; the block itself needs no extra synchronizer.

Configuration
REQ-024 SHALL, with MUX2_ARB_ROUND_ROBIN_EN defined, apply the tie rule of REQ-015.
REQ-025 SHALL, with MUX2_ARB_ROUND_ROBIN_EN undefined, resolve every tie in favour of A, remove the last-winner register, and exclude REQ-018 from verification.

Verification
REQ-026 SHALL cover the reset test: reset_n=0 with a_valid=b_valid=1 -> out_valid=0, a_ready=b_ready=0, select=0; after release, GRANT_A one cycle later.
REQ-027 SHALL cover a single requester: b_valid=1, b_data=0x5 (BITS=4), out_ready=1 -> next cycle select=1, out_valid=1, out_data=0x5, b_ready=1.
REQ-028 SHALL cover round-robin: both valid continuously with out_ready=1 -> grants A,B,A,B on consecutive cycles with no IDLE bubble.
REQ-029 SHALL cover backpressure: GRANT_A with out_ready=0 for 3 cycles while b_valid=1 -> state stays GRANT_A, a_ready=0, select=0; A transfers on out_ready=1.
REQ-030 SHALL cover a valid drop: GRANT_B, then b_valid falls with out_ready=0 -> IDLE next cycle and out_valid=0.
REQ-031 SHALL cover fixed priority (macro undefined): both valid continuously with out_ready=1 -> A granted every cycle and b_ready never high.
